// File: rtl/ff_pkg.sv
// Shared types and widths for the projectile slot arbiter.
package ff_pkg;

   localparam int unsigned CD_W = 8;

   typedef enum logic [1:0] {
      REQ_IDLE    = 2'd0,
      REQ_PENDING = 2'd1,
      REQ_COOL    = 2'd2
   } req_state_t;

   typedef enum logic {
      OWN_PLAYER = 1'b0,
      OWN_NPC    = 1'b1
   } owner_t;

endpackage

// File: rtl/shot_requester.sv
// One shooter: captures a fire edge, waits for a slot, then holds off for a frame-counted cooldown.
module shot_requester
   import ff_pkg::*;
#(
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic req,
   input  logic enable,
   input  logic grant,
   input  logic frame_tick,
   output logic pending,
   output logic cool
);

   req_state_t      state, state_nx;
   logic [CD_W-1:0] cnt, cnt_nx;
   logic            req_q;
   logic            req_rise;

   assign req_rise = req & ~req_q;

   // Previous req level; always tracks so a held level never re-fires after a drop.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) req_q <= 1'b0;
      else        req_q <= req;
   end

   // State, cooldown counter and registered status flags.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= REQ_IDLE;
         cnt     <= '0;
         pending <= 1'b0;
         cool    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         pending <= (state_nx == REQ_PENDING);
         cool    <= (cnt_nx != '0);
      end
   end

   // Next state: edges outside IDLE are dropped; the counter saturates at zero.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (!enable) begin
         state_nx = REQ_IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            REQ_IDLE: begin
               if (req_rise) state_nx = REQ_PENDING;
            end
            REQ_PENDING: begin
               if (grant) begin
                  state_nx = REQ_COOL;
                  cnt_nx   = CD_W'(COOLDOWN_FRAMES);
               end
            end
            REQ_COOL: begin
               if (frame_tick && (cnt != '0)) cnt_nx = cnt - CD_W'(1);
               if (cnt_nx == '0) state_nx = REQ_IDLE;
            end
            default: begin
               state_nx = REQ_IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/proj_slot_arbiter.sv
// Shares a pool of projectile slots between the player and NPC shooters, one launch per cycle.
module proj_slot_arbiter
   import ff_pkg::*;
#(
   parameter int unsigned NUM_SLOTS       = 4,
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 frame_clk,
   input  logic                 enable,
   input  logic                 player_req,
   input  logic                 npc_req,
   input  logic [NUM_SLOTS-1:0] slot_done,
   output logic [NUM_SLOTS-1:0] slot_launch,
   output logic [NUM_SLOTS-1:0] slot_owner,
   output logic [NUM_SLOTS-1:0] slot_busy,
   output logic                 player_grant,
   output logic                 npc_grant,
   output logic                 player_cool,
   output logic                 npc_cool
);

   logic                 fs1, fs2, fs3;
   logic                 frame_tick;
   logic [NUM_SLOTS-1:0] free_slots;
   logic [NUM_SLOTS-1:0] lowest_free;
   logic                 any_free;
   logic                 player_pend, npc_pend;
   logic                 player_grant_c, npc_grant_c;
   logic [NUM_SLOTS-1:0] launch_c;
   logic [NUM_SLOTS-1:0] done_valid;
   owner_t               rr_ptr, rr_ptr_nx;

   // Two-flop sync of VGA_VS plus one more stage for rising-edge detection.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) {fs3, fs2, fs1} <= 3'b000;
      else        {fs3, fs2, fs1} <= {fs2, fs1, frame_clk};
   end

   assign frame_tick  = fs2 & ~fs3;
   assign free_slots  = ~slot_busy;
   assign lowest_free = free_slots & (~free_slots + NUM_SLOTS'(1));
   assign any_free    = |free_slots;
   assign done_valid  = slot_done & slot_busy;

   shot_requester #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_player (
      .Clk        (Clk),
      .Reset      (Reset),
      .req        (player_req),
      .enable     (enable),
      .grant      (player_grant_c),
      .frame_tick (frame_tick),
      .pending    (player_pend),
      .cool       (player_cool)
   );

   shot_requester #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_npc (
      .Clk        (Clk),
      .Reset      (Reset),
      .req        (npc_req),
      .enable     (enable),
      .grant      (npc_grant_c),
      .frame_tick (frame_tick),
      .pending    (npc_pend),
      .cool       (npc_cool)
   );

   // Grant selection: a lone requester always wins; a tie goes to the pointer, which then flips.
   always_comb begin
      player_grant_c = 1'b0;
      npc_grant_c    = 1'b0;
      rr_ptr_nx      = rr_ptr;
      if (enable && any_free) begin
         if (player_pend && npc_pend) begin
            player_grant_c = (rr_ptr == OWN_PLAYER);
            npc_grant_c    = (rr_ptr == OWN_NPC);
            rr_ptr_nx      = (rr_ptr == OWN_PLAYER) ? OWN_NPC : OWN_PLAYER;
         end else begin
            player_grant_c = player_pend;
            npc_grant_c    = npc_pend;
         end
      end
      launch_c = (player_grant_c || npc_grant_c) ? lowest_free : '0;
   end

   // Round-robin pointer survives enable drops; only reset clears it.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) rr_ptr <= OWN_PLAYER;
      else        rr_ptr <= rr_ptr_nx;
   end

   // Slot occupancy, ownership and launch pulses; a released slot reads back as player-owned.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         slot_busy    <= '0;
         slot_owner   <= '0;
         slot_launch  <= '0;
         player_grant <= 1'b0;
         npc_grant    <= 1'b0;
      end else if (!enable) begin
         slot_busy    <= '0;
         slot_owner   <= '0;
         slot_launch  <= '0;
         player_grant <= 1'b0;
         npc_grant    <= 1'b0;
      end else begin
         slot_busy    <= (slot_busy & ~done_valid) | launch_c;
         slot_owner   <= (slot_owner & ~done_valid) | (npc_grant_c ? launch_c : '0);
         slot_launch  <= launch_c;
         player_grant <= player_grant_c;
         npc_grant    <= npc_grant_c;
      end
   end

endmodule
